// File: rtl/countdown_timer_ctrl.sv
// Countdown sequencer for the seven-segment display: loads a BCD preset,
// decrements once per prescaled second, pulses expired at 00, then holds 00.
module countdown_timer_ctrl #(
  parameter int TICK_DIV  = 100000000,
  parameter int HOLD_SECS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] preset_bcd,
  input  logic       pause,
  input  logic       cancel,
  output logic [8:0] seconds,
  output logic       busy,
  output logic       expired,
  output logic       load_err
);

  localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TERM      = PW'(TICK_DIV - 1);
  localparam logic [3:0]    HOLD_LAST = 4'(HOLD_SECS - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

  state_t        r_state, w_stateNext;
  logic [PW-1:0] r_presc, w_prescNext;
  logic [3:0]    r_tens, w_tensNext;
  logic [3:0]    r_ones, w_onesNext;
  logic [3:0]    r_hold, w_holdNext;
  logic          r_show, w_showNext;
  logic          r_expired, w_expiredNext;
  logic          r_loadErr, w_loadErrNext;
  logic          r_busy;
  logic          w_validPreset;
  logic          w_term;

  assign w_validPreset = (preset_bcd[7:4] <= 4'd9) && (preset_bcd[3:0] <= 4'd9) &&
                         (preset_bcd != 8'h00);
  assign w_term        = (r_presc == TERM);

  // An invalid start only raises load_err; the cycle is otherwise handled normally.
  always_comb begin
    w_stateNext   = r_state;
    w_prescNext   = r_presc;
    w_tensNext    = r_tens;
    w_onesNext    = r_ones;
    w_holdNext    = r_hold;
    w_showNext    = r_show;
    w_expiredNext = 1'b0;
    w_loadErrNext = 1'b0;

    if (cancel && (r_state != IDLE)) begin
      w_stateNext = IDLE;
      w_prescNext = '0;
      w_tensNext  = 4'd0;
      w_onesNext  = 4'd0;
      w_holdNext  = 4'd0;
      w_showNext  = 1'b0;
    end else if (start && w_validPreset) begin
      w_stateNext = RUN;
      w_prescNext = '0;
      w_tensNext  = preset_bcd[7:4];
      w_onesNext  = preset_bcd[3:0];
      w_holdNext  = 4'd0;
      w_showNext  = 1'b1;
    end else begin
      w_loadErrNext = start;
      case (r_state)
        IDLE: begin
        end
        RUN, PAUSED: begin
          if (pause) begin
            w_stateNext = PAUSED;
          end else begin
            w_stateNext = RUN;
            if (w_term) begin
              w_prescNext = '0;
              if ((r_tens == 4'd0) && (r_ones == 4'd1)) begin
                w_onesNext    = 4'd0;
                w_holdNext    = 4'd0;
                w_expiredNext = 1'b1;
                w_stateNext   = DONE;
              end else if (r_ones != 4'd0) begin
                w_onesNext = r_ones - 4'd1;
              end else begin
                w_onesNext = 4'd9;
                w_tensNext = r_tens - 4'd1;
              end
            end else begin
              w_prescNext = r_presc + 1'b1;
            end
          end
        end
        DONE: begin
          if (w_term) begin
            w_prescNext = '0;
            if (r_hold == HOLD_LAST) begin
              w_stateNext = IDLE;
              w_holdNext  = 4'd0;
              w_showNext  = 1'b0;
              w_tensNext  = 4'd0;
              w_onesNext  = 4'd0;
            end else begin
              w_holdNext = r_hold + 4'd1;
            end
          end else begin
            w_prescNext = r_presc + 1'b1;
          end
        end
        default: w_stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_presc   <= '0;
      r_tens    <= 4'd0;
      r_ones    <= 4'd0;
      r_hold    <= 4'd0;
      r_show    <= 1'b0;
      r_expired <= 1'b0;
      r_loadErr <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_presc   <= w_prescNext;
      r_tens    <= w_tensNext;
      r_ones    <= w_onesNext;
      r_hold    <= w_holdNext;
      r_show    <= w_showNext;
      r_expired <= w_expiredNext;
      r_loadErr <= w_loadErrNext;
      r_busy    <= (w_stateNext != IDLE);
    end
  end

  assign seconds  = {r_show, r_tens, r_ones};
  assign busy     = r_busy;
  assign expired  = r_expired;
  assign load_err = r_loadErr;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Scoreboard bench for countdown_timer_ctrl with TICK_DIV=4, HOLD_SECS=2:
// each driven cycle queues its expected outputs, a monitor pops and compares.
module tb_countdown_timer_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] preset_bcd;
  logic       pause;
  logic       cancel;
  logic [8:0] seconds;
  logic       busy;
  logic       expired;
  logic       load_err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [11:0] vec;
    string       name;
  } exp_t;

  exp_t q[$];

  countdown_timer_ctrl #(.TICK_DIV(4), .HOLD_SECS(2)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .preset_bcd(preset_bcd),
    .pause(pause),
    .cancel(cancel),
    .seconds(seconds),
    .busy(busy),
    .expired(expired),
    .load_err(load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] pack(input logic [8:0] sec, input logic bsy,
                                       input logic exp, input logic err);
    return {sec, bsy, exp, err};
  endfunction

  task automatic checkOutput(input string nm, input logic [11:0] act, input logic [11:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s: got sec=%h busy=%b exp=%b err=%b, want sec=%h busy=%b exp=%b err=%b",
               nm, act[11:3], act[2], act[1], act[0], want[11:3], want[2], want[1], want[0]);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue the response for the next rising edge.
  task automatic applyStimulus(input logic st, input logic [7:0] pre, input logic pa,
                               input logic ca, input logic [8:0] eSec, input logic eBusy,
                               input logic eExp, input logic eErr, input string nm);
    exp_t e;
    @(negedge clk);
    start      = st;
    preset_bcd = pre;
    pause      = pa;
    cancel     = ca;
    e.vec      = pack(eSec, eBusy, eExp, eErr);
    e.name     = nm;
    q.push_back(e);
  endtask

  task automatic runCycles(input int n, input logic pa, input logic [8:0] eSec,
                           input logic eBusy, input string nm);
    repeat (n) applyStimulus(1'b0, 8'h00, pa, 1'b0, eSec, eBusy, 1'b0, 1'b0, nm);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checkOutput(e.name, pack(seconds, busy, expired, load_err), e.vec);
      end
    end
  end

  initial begin : stimulus
    reset      = 1'b0;
    start      = 1'b0;
    preset_bcd = 8'h00;
    pause      = 1'b0;
    cancel     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset state", pack(seconds, busy, expired, load_err), 12'h000);
    @(negedge clk);
    reset = 1'b1;

    // Load, ticks and borrow.
    applyStimulus(1, 8'h12, 0, 0, 9'h112, 1, 0, 0, "t1 load 12");
    runCycles(3, 0, 9'h112, 1, "t1 hold 12");
    applyStimulus(0, 8'h00, 0, 0, 9'h111, 1, 0, 0, "t1 tick 11");
    runCycles(3, 0, 9'h111, 1, "t1 hold 11");
    applyStimulus(0, 8'h00, 0, 0, 9'h110, 1, 0, 0, "t1 tick 10");
    runCycles(3, 0, 9'h110, 1, "t1 hold 10");
    applyStimulus(0, 8'h00, 0, 0, 9'h109, 1, 0, 0, "t1 borrow 09");
    applyStimulus(0, 8'h00, 0, 1, 9'h000, 0, 0, 0, "t1 cancel");

    // Expiry and hold release.
    applyStimulus(1, 8'h02, 0, 0, 9'h102, 1, 0, 0, "t2 load 02");
    runCycles(3, 0, 9'h102, 1, "t2 hold 02");
    applyStimulus(0, 8'h00, 0, 0, 9'h101, 1, 0, 0, "t2 tick 01");
    runCycles(3, 0, 9'h101, 1, "t2 hold 01");
    applyStimulus(0, 8'h00, 0, 0, 9'h100, 1, 1, 0, "t2 expire");
    runCycles(7, 0, 9'h100, 1, "t2 done hold");
    applyStimulus(0, 8'h00, 0, 0, 9'h000, 0, 0, 0, "t2 release");
    runCycles(1, 0, 9'h000, 0, "t2 idle");

    // Pause keeps the partial second.
    applyStimulus(1, 8'h05, 0, 0, 9'h105, 1, 0, 0, "t3 load 05");
    runCycles(2, 0, 9'h105, 1, "t3 run");
    runCycles(10, 1, 9'h105, 1, "t3 paused");
    applyStimulus(0, 8'h00, 0, 0, 9'h105, 1, 0, 0, "t3 resume");
    applyStimulus(0, 8'h00, 0, 0, 9'h104, 1, 0, 0, "t3 tick after resume");
    applyStimulus(0, 8'h00, 0, 1, 9'h000, 0, 0, 0, "t3 cancel");

    // Rejected presets, restart and reload while paused.
    applyStimulus(1, 8'h1A, 0, 0, 9'h000, 0, 0, 1, "t4 bad nibble");
    applyStimulus(1, 8'h00, 0, 0, 9'h000, 0, 0, 1, "t4 zero preset");
    runCycles(1, 0, 9'h000, 0, "t4 idle");
    applyStimulus(1, 8'h05, 0, 0, 9'h105, 1, 0, 0, "t4 load 05");
    applyStimulus(1, 8'h0A, 0, 0, 9'h105, 1, 0, 1, "t4 bad in run");
    runCycles(2, 0, 9'h105, 1, "t4 run on");
    applyStimulus(0, 8'h00, 0, 0, 9'h104, 1, 0, 0, "t4 tick 04");
    applyStimulus(1, 8'h99, 0, 0, 9'h199, 1, 0, 0, "t4 restart 99");
    runCycles(2, 1, 9'h199, 1, "t4 paused 99");
    applyStimulus(1, 8'h20, 1, 0, 9'h120, 1, 0, 0, "t4 reload in pause");
    runCycles(2, 1, 9'h120, 1, "t4 paused 20");
    runCycles(3, 0, 9'h120, 1, "t4 run 20");
    applyStimulus(0, 8'h00, 0, 0, 9'h119, 1, 0, 0, "t4 borrow 19");
    applyStimulus(0, 8'h00, 0, 1, 9'h000, 0, 0, 0, "t4 cancel");

    // Cancel beats a coinciding tick and start.
    applyStimulus(1, 8'h03, 0, 0, 9'h103, 1, 0, 0, "t5 load 03");
    runCycles(3, 0, 9'h103, 1, "t5 hold 03");
    applyStimulus(1, 8'h07, 0, 1, 9'h000, 0, 0, 0, "t5 cancel on tick");
    runCycles(1, 0, 9'h000, 0, "t5 idle");
    applyStimulus(1, 8'h01, 0, 0, 9'h101, 1, 0, 0, "t5 load 01");
    runCycles(3, 0, 9'h101, 1, "t5 hold 01");
    applyStimulus(0, 8'h00, 0, 1, 9'h000, 0, 0, 0, "t5 cancel at 01");
    runCycles(2, 0, 9'h000, 0, "t5 no expired");

    // Restart from DONE, then async reset mid-run.
    applyStimulus(1, 8'h01, 0, 0, 9'h101, 1, 0, 0, "t6 load 01");
    runCycles(3, 0, 9'h101, 1, "t6 hold 01");
    applyStimulus(0, 8'h00, 0, 0, 9'h100, 1, 1, 0, "t6 expire");
    runCycles(1, 1, 9'h100, 1, "t6 pause ignored");
    applyStimulus(1, 8'h07, 0, 0, 9'h107, 1, 0, 0, "t6 restart from done");
    runCycles(3, 0, 9'h107, 1, "t6 hold 07");
    applyStimulus(0, 8'h00, 0, 0, 9'h106, 1, 0, 0, "t6 tick 06");
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    checkOutput("t6 async reset", pack(seconds, busy, expired, load_err), 12'h000);
    repeat (2) begin
      @(posedge clk);
      #1;
      checkOutput("t6 reset held", pack(seconds, busy, expired, load_err), 12'h000);
    end
    @(negedge clk);
    reset = 1'b1;
    runCycles(2, 0, 9'h000, 0, "t6 after reset");

    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain: got %0d pending entries, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
